// File: rtl/prog_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : prog_run_sequencer
// Description : Runs NUM_PROGS core programs back-to-back. Each program is
//               loaded, run until halt or cycle limit, and its result captured.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_run_sequencer #(
    parameter int NUM_PROGS   = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LOAD_CYCLES = 2,
    parameter int MAX_CYCLES  = 100,
    parameter int CNT_W       = 16,
    localparam int c_IDX_W    = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_PROGS*ADDR_W-1:0] start_pcs,
    input  logic                        core_halt,
    input  logic [DATA_W-1:0]           core_result,
    output logic                        core_run,
    output logic [ADDR_W-1:0]           core_pc_init,
    output logic                        busy,
    output logic                        res_valid,
    output logic [DATA_W-1:0]           res_data,
    output logic [c_IDX_W-1:0]          res_idx,
    output logic                        res_timeout,
    output logic                        done,
    output logic [4:0]                  timeout_cnt
);

    localparam int                 c_LOAD_W    = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [c_LOAD_W-1:0] c_LOAD_LAST = c_LOAD_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_RUN_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(NUM_PROGS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_LOAD_W-1:0] r_load_cnt;
    logic [CNT_W-1:0]    r_run_cnt;
    logic                r_tflag;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_res_data;
    logic [c_IDX_W-1:0]  r_res_idx;
    logic                r_res_to;
    logic [4:0]          r_tcnt;
    logic                w_pc_load;
    logic [c_IDX_W-1:0]  w_pc_idx;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_load   = 1'b0;
        w_pc_idx    = r_idx;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_pc_load   = 1'b1;
                    w_pc_idx    = '0;
                end
            end
            S_LOAD: begin
                if (r_load_cnt == c_LOAD_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Halt takes priority over the limit; the flag itself is set in the register process.
                if (core_halt || (r_run_cnt == c_RUN_LAST)) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (r_idx == c_IDX_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_LOAD;
                    w_pc_load   = 1'b1;
                    w_pc_idx    = r_idx + 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_load_cnt <= '0;
            r_run_cnt  <= '0;
            r_tflag    <= 1'b0;
            r_pc       <= '0;
            r_res_data <= '0;
            r_res_idx  <= '0;
            r_res_to   <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pc_load) begin
                r_idx <= w_pc_idx;
                r_pc  <= start_pcs[w_pc_idx*ADDR_W +: ADDR_W];
            end
            r_load_cnt <= (r_state == S_LOAD && w_state_nxt == S_LOAD) ? r_load_cnt + 1'b1 : '0;
            r_run_cnt  <= (r_state == S_RUN && w_state_nxt == S_RUN) ? r_run_cnt + 1'b1 : '0;
            if (r_state == S_RUN) begin
                r_tflag <= ~core_halt;
            end
            if (r_state == S_CAPTURE) begin
                r_res_data <= core_result;
                r_res_idx  <= r_idx;
                r_res_to   <= r_tflag;
                if (r_tflag && r_tcnt != 5'd31) begin
                    r_tcnt <= r_tcnt + 5'd1;
                end
            end
            if (r_state == S_IDLE && start) begin
                r_tcnt <= '0;
            end
        end
    end

    // Result outputs bypass the holding registers so data is valid alongside res_valid.
    assign core_run     = (r_state == S_RUN);
    assign busy         = (r_state != S_IDLE);
    assign res_valid    = (r_state == S_CAPTURE);
    assign done         = (r_state == S_DONE);
    assign core_pc_init = r_pc;
    assign res_data     = res_valid ? core_result : r_res_data;
    assign res_idx      = res_valid ? r_idx : r_res_idx;
    assign res_timeout  = res_valid ? r_tflag : r_res_to;
    assign timeout_cnt  = r_tcnt;

endmodule
`default_nettype wire

// File: tb/tb_prog_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_run_sequencer
// Description : Scoreboard bench for prog_run_sequencer with a behavioural core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_run_sequencer;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [NP*AW-1:0] start_pcs;
    logic            core_halt;
    logic [DW-1:0]   core_result;
    logic            core_run;
    logic [AW-1:0]   core_pc_init;
    logic            busy;
    logic            res_valid;
    logic [DW-1:0]   res_data;
    logic [0:0]      res_idx;
    logic            res_timeout;
    logic            done;
    logic [4:0]      timeout_cnt;

    prog_run_sequencer #(
        .NUM_PROGS(NP), .ADDR_W(AW), .DATA_W(DW),
        .LOAD_CYCLES(2), .MAX_CYCLES(100), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_pcs(start_pcs),
        .core_halt(core_halt), .core_result(core_result),
        .core_run(core_run), .core_pc_init(core_pc_init), .busy(busy),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
        .res_timeout(res_timeout), .done(done), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        idx;
        logic [31:0] data;
        logic        tout;
    } res_t;

    res_t          exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            done_exp = 0;
    int            halt_at[NP];
    logic [AW-1:0] exp_pc[NP];
    int            run_len[NP];
    int            p = 0;
    int            rc = 0;
    logic          halt_outside = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic res_t mk(input logic i, input logic [31:0] d, input logic t);
        mk = {i, d, t};
    endfunction

    function automatic logic [31:0] pc_result(input logic [31:0] pc);
        case (pc)
            32'd0:   pc_result = 32'd7;
            32'd56:  pc_result = 32'd42;
            default: pc_result = pc + 32'd1000;
        endcase
    endfunction

    // Behavioural core: counts run cycles, halts at the programmed run cycle.
    initial begin
        core_halt   = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rc        = 0;
                core_halt = 1'b0;
            end else if (core_run) begin
                if (rc == 0) check("pc_init", core_pc_init, exp_pc[p]);
                core_halt = (rc == halt_at[p]);
                rc++;
            end else begin
                if (rc != 0) begin
                    if (p < NP) run_len[p] = rc;
                    p++;
                    rc = 0;
                end
                core_halt = halt_outside;
            end
            core_result = pc_result(core_pc_init);
        end
    end

    // Monitor: pops the scoreboard on every result pulse.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid) begin
                if (exp_q.size() == 0) begin
                    check("res_unexpected", res_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_idx", res_idx, e.idx);
                    check("res_data", res_data, e.data);
                    check("res_timeout", res_timeout, e.tout);
                end
            end
            if (!rst && done) begin
                check("done_expected", done_exp, 1);
                done_exp = 0;
            end
        end
    end

    task automatic check_zero(input string tag);
        check(tag, {core_run, busy, res_valid, done, res_timeout, timeout_cnt, res_idx}, 0);
        check({tag, "_pc"}, core_pc_init, 0);
        check({tag, "_data"}, res_data, 0);
    endtask

    task automatic run_seq(input int h0, input int h1, input res_t e0, input res_t e1,
                           input int exp_cycles, input logic [4:0] exp_tc,
                           input int exp_len0, input logic pulse_start);
        int   n;
        logic injected;
        halt_at[0] = h0;
        halt_at[1] = h1;
        p          = 0;
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        done_exp = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        n        = 1;
        injected = 1'b0;
        while (done !== 1'b1 && n < 1000) begin
            if (pulse_start && core_run && !injected) begin
                start    = 1'b1;
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("seq_cycles", n, exp_cycles);
        @(negedge clk);
        check("busy_after_done", {busy, done}, 2'b00);
        check("timeout_cnt", timeout_cnt, exp_tc);
        check("run_len0", run_len[0], exp_len0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        start     = 1'b1;
        start_pcs = {32'd56, 32'd0};
        exp_pc[0] = 32'd0;
        exp_pc[1] = 32'd56;
        halt_at[0] = -1;
        halt_at[1] = -1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        start = 1'b0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // Two programs halting 20 cycles into each run: (2+21+1)*2 + 1 = 49.
        run_seq(20, 20, mk(1'b0, 32'd7, 1'b0), mk(1'b1, 32'd42, 1'b0), 49, 5'd0, 21, 1'b0);
        // Program 0 times out: (2+100+1) + (2+21+1) + 1 = 128.
        run_seq(-1, 20, mk(1'b0, 32'd7, 1'b1), mk(1'b1, 32'd42, 1'b0), 128, 5'd1, 100, 1'b0);
        // Halt coincides with the limit on program 0; program 1 times out.
        run_seq(99, -1, mk(1'b0, 32'd7, 1'b0), mk(1'b1, 32'd42, 1'b1), 207, 5'd1, 100, 1'b0);
        // Stray start during RUN and halt held outside RUN change nothing.
        halt_outside = 1'b1;
        run_seq(20, 20, mk(1'b0, 32'd7, 1'b0), mk(1'b1, 32'd42, 1'b0), 49, 5'd0, 21, 1'b1);
        halt_outside = 1'b0;

        // Abort during program 1 run.
        halt_at[0] = -1;
        halt_at[1] = -1;
        p          = 0;
        exp_q.push_back(mk(1'b0, 32'd7, 1'b1));
        done_exp = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(p == 1 && rc > 5) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_bound", n < 1000, 1'b1);
        check("abort_tcnt_before", timeout_cnt, 5'd1);
        #2 rst = 1'b1;
        #1 check_zero("abort");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("abort_queue", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("abort_idle", {busy, core_run}, 2'b00);

        run_seq(20, 20, mk(1'b0, 32'd7, 1'b0), mk(1'b1, 32'd42, 1'b0), 49, 5'd0, 21, 1'b0);
        repeat (2) @(negedge clk);
        check("queue_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
